// File: rtl/audio_path_ctrl.sv
// Playback path sequencer: effect selection, debounced volume control and click-free effect switching.
// Define AUDIO_CTRL_FADE_EN to enable the fade-out/switch/fade-in sequence; otherwise effect changes switch directly.
module audio_path_ctrl #(
    parameter int DATA_W       = 12,
    parameter int VOL_RESET    = 8,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] mic_pData,
    input  logic [DATA_W-1:0] lowpass_data,
    input  logic [DATA_W-1:0] echo_data,
    input  logic              echo_en,
    input  logic              lowpass_en,
    input  logic              plus,
    input  logic              minus,
    output logic [15:0]       i2s_pData,
    output logic [3:0]        vol,
    output logic [1:0]        mode,
    output logic              lowpass_run,
    output logic              echo_run,
    output logic              effect_clr,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        STEADY   = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        fade_q;
    logic [3:0]        vol_q;
    logic [3:0]        in_s1, in_s2;
    logic [1:0]        req;
    logic [1:0]        btn_db;
    logic [1:0]        btn_rise;
    logic [CNT_W-1:0]  db_cnt [2];
    logic signed [DATA_W-1:0] sel_p0;
    logic [3:0]        gain_p0;
    logic signed [15:0] scaled_p1;
`ifdef AUDIO_CTRL_FADE_EN
    logic [3:0]        fade_d;
`endif

    function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
        return (a < b) ? a : b;
    endfunction

    // Unsigned 4-bit gain treated as a positive 5-bit signed factor; 12x5 product fits 16 bits.
    function automatic logic signed [15:0] scale(input logic signed [DATA_W-1:0] s,
                                                 input logic [3:0] g);
        logic signed [DATA_W+4:0] p;
        p = s * $signed({1'b0, g});
        return 16'(p);
    endfunction

    // Synchroniser stage: {echo_en, lowpass_en, plus, minus}
    always_ff @(posedge clk) begin
        if (rst) begin
            in_s1 <= '0;
            in_s2 <= '0;
        end else begin
            in_s1 <= {echo_en, lowpass_en, plus, minus};
            in_s2 <= in_s1;
        end
    end

    always_comb begin
        req = in_s2[3] ? 2'd2 : (in_s2[2] ? 2'd1 : 2'd0);
    end

    // Debounce stage: index 1 = plus, index 0 = minus
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db   <= '0;
            btn_rise <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                btn_rise[i] <= 1'b0;
                if (in_s2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    btn_db[i]   <= in_s2[i];
                    btn_rise[i] <= in_s2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vol_q <= 4'(VOL_RESET);
        end else begin
            case (btn_rise)
                2'b10:   if (vol_q != 4'd15) vol_q <= vol_q + 4'd1;
                2'b01:   if (vol_q != 4'd0)  vol_q <= vol_q - 4'd1;
                default: vol_q <= vol_q;
            endcase
        end
    end

    // Datapath stage p0: select and gain
    always_comb begin
        case (mode_q)
            2'd1:    sel_p0 = $signed(lowpass_data);
            2'd2:    sel_p0 = $signed(echo_data);
            default: sel_p0 = $signed(mic_pData);
        endcase
        gain_p0 = min4(vol_q, fade_q);
    end

    // Datapath stage p1: registered scaled sample, held between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            scaled_p1 <= '0;
        end else if (sample_valid) begin
            scaled_p1 <= scale(sel_p0, gain_p0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STEADY;
            mode_q  <= 2'd0;
`ifdef AUDIO_CTRL_FADE_EN
            fade_q  <= 4'd15;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
`ifdef AUDIO_CTRL_FADE_EN
            fade_q  <= fade_d;
`endif
        end
    end

`ifndef AUDIO_CTRL_FADE_EN
    assign fade_q = 4'd15;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
`ifdef AUDIO_CTRL_FADE_EN
        fade_d  = fade_q;
`endif
        case (state_q)
            STEADY: begin
                if (req != mode_q) begin
`ifdef AUDIO_CTRL_FADE_EN
                    state_d = FADE_OUT;
`else
                    state_d = SWITCH;
`endif
                end
            end
            SWITCH: begin
                mode_d = req;
`ifdef AUDIO_CTRL_FADE_EN
                state_d = FADE_IN;
`else
                state_d = STEADY;
`endif
            end
`ifdef AUDIO_CTRL_FADE_EN
            FADE_OUT: begin
                // A request that returns to the current mode aborts without switching.
                if (req == mode_q) begin
                    state_d = FADE_IN;
                end else if (fade_q == 4'd0) begin
                    state_d = SWITCH;
                end else if (sample_valid) begin
                    fade_d = fade_q - 4'd1;
                    if (fade_q == 4'd1) state_d = SWITCH;
                end
            end
            FADE_IN: begin
                if (req != mode_q) begin
                    state_d = FADE_OUT;
                end else if (fade_q == 4'd15) begin
                    state_d = STEADY;
                end else if (sample_valid) begin
                    fade_d = fade_q + 4'd1;
                    if (fade_q == 4'd14) state_d = STEADY;
                end
            end
`endif
            default: state_d = STEADY;
        endcase
    end

    assign i2s_pData   = scaled_p1;
    assign vol         = vol_q;
    assign mode        = mode_q;
    assign lowpass_run = (mode_q == 2'd1);
    assign echo_run    = (mode_q == 2'd2);
    assign effect_clr  = (state_q == SWITCH);
    assign busy        = (state_q != STEADY);

endmodule

// File: tb/tb_audio_path_ctrl.sv
// Directed bench for audio_path_ctrl with DEBOUNCE_CYC=4; covers the fade build when AUDIO_CTRL_FADE_EN is defined.
module tb_audio_path_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_pData = '0;
    logic [11:0] lowpass_data = '0;
    logic [11:0] echo_data = '0;
    logic        echo_en = 1'b0;
    logic        lowpass_en = 1'b0;
    logic        plus = 1'b0;
    logic        minus = 1'b0;
    logic [15:0] i2s_pData;
    logic [3:0]  vol;
    logic [1:0]  mode;
    logic        lowpass_run;
    logic        echo_run;
    logic        effect_clr;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    int clr_cnt  = 0;
    int clr0;

    audio_path_ctrl #(.DATA_W(12), .VOL_RESET(8), .DEBOUNCE_CYC(4)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .mic_pData(mic_pData), .lowpass_data(lowpass_data), .echo_data(echo_data),
        .echo_en(echo_en), .lowpass_en(lowpass_en), .plus(plus), .minus(minus),
        .i2s_pData(i2s_pData), .vol(vol), .mode(mode), .lowpass_run(lowpass_run),
        .echo_run(echo_run), .effect_clr(effect_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (effect_clr) clr_cnt <= clr_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic strobe_check(input string tag, input int exp);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check(tag, int'($signed(i2s_pData)), exp);
    endtask

    task automatic press_plus();
        plus = 1'b1;
        repeat (10) tick();
        plus = 1'b0;
        repeat (10) tick();
    endtask

    task automatic press_minus();
        minus = 1'b1;
        repeat (10) tick();
        minus = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check("rst_i2s", int'(i2s_pData), 0);
        check("rst_vol", int'(vol), 8);
        check("rst_mode", int'(mode), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_clr", int'(effect_clr), 0);

        mic_pData = 12'sd100;
        strobe_check("bypass_800", 800);

        press_plus();
        check("vol_plus1", int'(vol), 9);
        repeat (8) press_plus();
        check("vol_sat15", int'(vol), 15);
        repeat (3) begin
            minus = 1'b1;
            repeat (2) tick();
            minus = 1'b0;
            repeat (2) tick();
        end
        repeat (10) tick();
        check("vol_bounce", int'(vol), 15);
        strobe_check("gain15", 1500);
        repeat (7) press_minus();
        check("vol_back8", int'(vol), 8);

`ifdef AUDIO_CTRL_FADE_EN
        // Aborted switch: echo requested, then withdrawn at fade=10
        echo_data = 12'sd100;
        lowpass_data = 12'sd50;
        clr0 = clr_cnt;
        echo_en = 1'b1;
        repeat (4) tick();
        check("abort_busy", int'(busy), 1);
        for (int k = 0; k < 5; k++) strobe_check("abort_down", 800);
        echo_en = 1'b0;
        repeat (4) tick();
        check("abort_mode", int'(mode), 0);
        for (int k = 0; k < 5; k++) strobe_check("abort_up", 800);
        check("abort_idle", int'(busy), 0);
        check("abort_noclr", clr_cnt - clr0, 0);

        // Full switch to echo
        clr0 = clr_cnt;
        echo_en = 1'b1;
        repeat (4) tick();
        check("fade_busy", int'(busy), 1);
        for (int k = 0; k < 15; k++) begin
            int f;
            f = 15 - k;
            strobe_check("fade_out", ((f < 8) ? f : 8) * 100);
        end
        check("switch_clr", int'(effect_clr), 1);
        check("switch_oldmode", int'(mode), 0);
        tick();
        check("switch_mode", int'(mode), 2);
        check("switch_echo_run", int'(echo_run), 1);
        check("switch_clr_end", int'(effect_clr), 0);
        for (int k = 0; k < 15; k++) begin
            check("fade_in_busy", int'(busy), 1);
            strobe_check("fade_in", ((k < 8) ? k : 8) * 100);
        end
        check("fade_done", int'(busy), 0);
        check("fade_clr_cnt", clr_cnt - clr0, 1);

        lowpass_en = 1'b1;
        repeat (4) tick();
        check("prio_mode", int'(mode), 2);
        check("prio_busy", int'(busy), 0);
`else
        // Direct switch to lowpass, no gain ramp
        clr0 = clr_cnt;
        lowpass_en = 1'b1;
        repeat (4) tick();
        check("direct_clr", clr_cnt - clr0, 1);
        check("direct_mode", int'(mode), 1);
        check("direct_lp_run", int'(lowpass_run), 1);
        check("direct_busy", int'(busy), 0);
        lowpass_data = 12'sd300;
        strobe_check("direct_gain", 2400);

        echo_en = 1'b1;
        repeat (4) tick();
        check("prio_mode", int'(mode), 2);
        check("prio_echo_run", int'(echo_run), 1);
        check("prio_clr", clr_cnt - clr0, 2);
`endif

        repeat (7) press_plus();
        check("max_vol", int'(vol), 15);
        mic_pData = 12'h800;
        echo_data = 12'h800;
        strobe_check("neg_full", -30720);
        check("neg_raw", int'(i2s_pData), 32'h8800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
